// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned NUM_MASTERS  = 2;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int unsigned TIMEOUT_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// ACK watchdog: counts stalled strobe cycles and flags expiry for one cycle.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [TIMEOUT_W-1:0] count;

  assign expire_o = (count == TIMEOUT_W'(LIMIT));

  // Stall counter; restarts on ACK, grant change or after firing
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || ack_i || expire_o) begin
      count <= '0;
    end else if (stb_i) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone B4 classic round-robin arbiter.
// Grant is held for the whole CYC burst; ACK/data return to the owner only.
// Optional ACK watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    M0_CYC_I,
  input  logic                    M0_STB_I,
  input  logic                    M0_WE_I,
  input  logic [DATA_WIDTH/8-1:0] M0_SEL_I,
  input  logic [ADDR_WIDTH-1:0]   M0_ADR_I,
  input  logic [DATA_WIDTH-1:0]   M0_DAT_I,
  output logic [DATA_WIDTH-1:0]   M0_DAT_O,
  output logic                    M0_ACK_O,
  input  logic                    M1_CYC_I,
  input  logic                    M1_STB_I,
  input  logic                    M1_WE_I,
  input  logic [DATA_WIDTH/8-1:0] M1_SEL_I,
  input  logic [ADDR_WIDTH-1:0]   M1_ADR_I,
  input  logic [DATA_WIDTH-1:0]   M1_DAT_I,
  output logic [DATA_WIDTH-1:0]   M1_DAT_O,
  output logic                    M1_ACK_O,
  output logic                    S_CYC_O,
  output logic                    S_STB_O,
  output logic                    S_WE_O,
  output logic [DATA_WIDTH/8-1:0] S_SEL_O,
  output logic [ADDR_WIDTH-1:0]   S_ADR_O,
  output logic [DATA_WIDTH-1:0]   S_DAT_O,
  input  logic [DATA_WIDTH-1:0]   S_DAT_I,
  input  logic                    S_ACK_I,
  output logic [NUM_MASTERS-1:0]  gnt_o,
  output logic                    timeout_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_t            state, state_next;
  logic                  last, last_next;   // 1 = M1 was granted last
  logic                  cyc_raw, stb_raw;
  logic                  expire;
  logic                  ack_src;
  logic [DATA_WIDTH-1:0] rd_data;

  // State and last-grant pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Round-robin grant; release and handoff to a waiting peer happen on one edge
  always_comb begin
    state_next = state;
    last_next  = last;
    unique case (state)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_next = last ? GNT0 : GNT1;
        end else if (M0_CYC_I) begin
          state_next = GNT0;
        end else if (M1_CYC_I) begin
          state_next = GNT1;
        end
      end
      GNT0: begin
        if (!M0_CYC_I) begin
          last_next  = 1'b0;
          state_next = M1_CYC_I ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!M1_CYC_I) begin
          last_next  = 1'b1;
          state_next = M0_CYC_I ? GNT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_o = {state == GNT1, state == GNT0};

  // Downstream request mux; watchdog expiry masks CYC/STB for one cycle
  always_comb begin
    cyc_raw = 1'b0;
    stb_raw = 1'b0;
    S_WE_O  = 1'b0;
    S_SEL_O = '0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    unique case (state)
      GNT0: begin
        cyc_raw = M0_CYC_I;
        stb_raw = M0_STB_I;
        S_WE_O  = M0_WE_I;
        S_SEL_O = M0_SEL_I;
        S_ADR_O = M0_ADR_I;
        S_DAT_O = M0_DAT_I;
      end
      GNT1: begin
        cyc_raw = M1_CYC_I;
        stb_raw = M1_STB_I;
        S_WE_O  = M1_WE_I;
        S_SEL_O = M1_SEL_I;
        S_ADR_O = M1_ADR_I;
        S_DAT_O = M1_DAT_I;
      end
      default: ;
    endcase
    S_CYC_O = cyc_raw & ~expire;
    S_STB_O = stb_raw & ~expire;
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .stb_i   (stb_raw),
    .ack_i   (S_ACK_I),
    .clr_i   (state_next != state),
    .expire_o(expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign timeout_o = expire;
  assign ack_src   = S_ACK_I | expire;
  assign rd_data   = expire ? DATA_WIDTH'(TIMEOUT_DATA) : S_DAT_I;

  // Response demux: only the owner sees ACK and read data
  always_comb begin
    M0_ACK_O = gnt_o[0] & ack_src;
    M1_ACK_O = gnt_o[1] & ack_src;
    M0_DAT_O = gnt_o[0] ? rd_data : '0;
    M1_DAT_O = gnt_o[1] ? rd_data : '0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed stimulus pushes expected ACK
// responses; a negedge monitor pops and compares whenever an ACK appears.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        M0_CYC_I, M0_STB_I, M0_WE_I;
  logic [3:0]  M0_SEL_I;
  logic [31:0] M0_ADR_I, M0_DAT_I, M0_DAT_O;
  logic        M0_ACK_O;
  logic        M1_CYC_I, M1_STB_I, M1_WE_I;
  logic [3:0]  M1_SEL_I;
  logic [31:0] M1_ADR_I, M1_DAT_I, M1_DAT_O;
  logic        M1_ACK_O;
  logic        S_CYC_O, S_STB_O, S_WE_O;
  logic [3:0]  S_SEL_O;
  logic [31:0] S_ADR_O, S_DAT_O, S_DAT_I;
  logic        S_ACK_I;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          m;
    logic [31:0] d;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_d;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .M0_CYC_I (M0_CYC_I),
    .M0_STB_I (M0_STB_I),
    .M0_WE_I  (M0_WE_I),
    .M0_SEL_I (M0_SEL_I),
    .M0_ADR_I (M0_ADR_I),
    .M0_DAT_I (M0_DAT_I),
    .M0_DAT_O (M0_DAT_O),
    .M0_ACK_O (M0_ACK_O),
    .M1_CYC_I (M1_CYC_I),
    .M1_STB_I (M1_STB_I),
    .M1_WE_I  (M1_WE_I),
    .M1_SEL_I (M1_SEL_I),
    .M1_ADR_I (M1_ADR_I),
    .M1_DAT_I (M1_DAT_I),
    .M1_DAT_O (M1_DAT_O),
    .M1_ACK_O (M1_ACK_O),
    .S_CYC_O  (S_CYC_O),
    .S_STB_O  (S_STB_O),
    .S_WE_O   (S_WE_O),
    .S_SEL_O  (S_SEL_O),
    .S_ADR_O  (S_ADR_O),
    .S_DAT_O  (S_DAT_O),
    .S_DAT_I  (S_DAT_I),
    .S_ACK_I  (S_ACK_I),
    .gnt_o    (gnt_o),
    .timeout_o(timeout_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  // Monitor: every ACK seen by a master must match the oldest expectation
  always @(negedge clk_i) begin
    if (!rst_i && (M0_ACK_O || M1_ACK_O)) begin
      total++;
      if (M0_ACK_O && M1_ACK_O) begin
        bad++;
        $display("FAIL sb_dual_ack: m0=%b m1=%b want one", M0_ACK_O, M1_ACK_O);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack: m0=%b m1=%b want none", M0_ACK_O, M1_ACK_O);
      end else begin
        mon_e = sb.pop_front();
        mon_d = M1_ACK_O ? M1_DAT_O : M0_DAT_O;
        if ((M1_ACK_O != mon_e.m) || (mon_d !== mon_e.d)) begin
          bad++;
          $display("FAIL sb_ack: got m%0d data %0h want m%0d data %0h",
                   M1_ACK_O, mon_d, mon_e.m, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst_i    = 1'b1;
    M0_CYC_I = 0; M0_STB_I = 0; M0_WE_I = 0; M0_SEL_I = '0; M0_ADR_I = '0; M0_DAT_I = '0;
    M1_CYC_I = 0; M1_STB_I = 0; M1_WE_I = 0; M1_SEL_I = '0; M1_ADR_I = '0; M1_DAT_I = '0;
    S_ACK_I  = 1'b1;
    S_DAT_I  = 32'hFFFF_0000;
    step();
    step();

    // Reset state, with a live ACK/data on the slave side
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_scyc", S_CYC_O, 0);
    check("rst_sstb", S_STB_O, 0);
    check("rst_sadr", S_ADR_O, 0);
    check("rst_m0ack", M0_ACK_O, 0);
    check("rst_m1ack", M1_ACK_O, 0);
    check("rst_m0dat", M0_DAT_O, 0);
    check("rst_m1dat", M1_DAT_O, 0);
    check("rst_timeout", timeout_o, 0);
    rst_i   = 1'b0;
    S_ACK_I = 1'b0;
    S_DAT_I = '0;

    // M0-only read of 0x40, ACK two cycles after grant
    M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 0; M0_SEL_I = 4'hF; M0_ADR_I = 32'h40;
    settle();
    check("t1_first_scyc", S_CYC_O, 0);
    check("t1_first_gnt", gnt_o, 2'b00);
    step();
    check("t1_gnt", gnt_o, 2'b01);
    check("t1_scyc", S_CYC_O, 1);
    check("t1_sadr", S_ADR_O, 32'h40);
    check("t1_swe", S_WE_O, 0);
    step();
    step();
    sb.push_back('{m: 1'b0, d: 32'h1234_5678});
    S_ACK_I = 1; S_DAT_I = 32'h1234_5678;
    settle();
    check("t1_m0ack", M0_ACK_O, 1);
    check("t1_m0dat", M0_DAT_O, 32'h1234_5678);
    check("t1_m1ack", M1_ACK_O, 0);
    check("t1_m1dat", M1_DAT_O, 0);
    step();
    S_ACK_I = 0; S_DAT_I = '0; M0_CYC_I = 0; M0_STB_I = 0;
    settle();
    check("t1_hold_gnt", gnt_o, 2'b01);
    step();
    check("t1_release_gnt", gnt_o, 2'b00);
    check("t1_release_scyc", S_CYC_O, 0);

    // Both request right after reset: M0 first, then direct handoff to M1
    rst_i = 1;
    step();
    rst_i = 0;
    M0_CYC_I = 1; M0_STB_I = 1; M0_ADR_I = 32'h100;
    M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 0; M1_SEL_I = 4'hF; M1_ADR_I = 32'h200;
    settle();
    check("t2_first_gnt", gnt_o, 2'b00);
    step();
    check("t2_gnt_m0", gnt_o, 2'b01);
    check("t2_sadr_m0", S_ADR_O, 32'h100);
    sb.push_back('{m: 1'b0, d: 32'hA0A0_0001});
    S_ACK_I = 1; S_DAT_I = 32'hA0A0_0001;
    settle();
    check("t2_m1ack_blocked", M1_ACK_O, 0);
    step();
    S_ACK_I = 0; S_DAT_I = '0; M0_CYC_I = 0; M0_STB_I = 0;
    settle();
    check("t2_gnt_before_edge", gnt_o, 2'b01);
    step();
    check("t2_handoff_gnt", gnt_o, 2'b10);
    check("t2_sadr_m1", S_ADR_O, 32'h200);
    sb.push_back('{m: 1'b1, d: 32'hB1B1_0002});
    S_ACK_I = 1; S_DAT_I = 32'hB1B1_0002;
    step();
    S_ACK_I = 0; S_DAT_I = '0;

    // M1 burst of five writes while M0 waits
    M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 0; M0_ADR_I = 32'h300;
    M1_WE_I = 1; M1_SEL_I = 4'hF;
    for (int i = 0; i < 5; i++) begin
      M1_ADR_I = 32'h10 + 32'(4 * i);
      M1_DAT_I = 32'hC000_0000 + 32'(i);
      settle();
      check("t3_sadr", S_ADR_O, 32'h10 + 32'(4 * i));
      check("t3_sdat", S_DAT_O, 32'hC000_0000 + 32'(i));
      check("t3_swe", S_WE_O, 1);
      check("t3_ssel", S_SEL_O, 4'hF);
      check("t3_gnt", gnt_o, 2'b10);
      sb.push_back('{m: 1'b1, d: 32'h0});
      S_ACK_I = 1;
      step();
      S_ACK_I = 0;
    end
    M1_CYC_I = 0; M1_STB_I = 0;
    step();
    check("t3_fair_gnt", gnt_o, 2'b01);
    M1_CYC_I = 1; M1_STB_I = 1; M1_WE_I = 0; M1_ADR_I = 32'h500;
    settle();
    check("t3_sadr_m0", S_ADR_O, 32'h300);
    step();
    check("t3_m0_keeps", gnt_o, 2'b01);
    M0_CYC_I = 0; M0_STB_I = 0;
    step();
    check("t3_m1_held_req", gnt_o, 2'b10);

    // Reset mid-read in GNT1, then a late ACK with nobody granted
    rst_i = 1;
    step();
    rst_i = 0;
    check("t4_gnt", gnt_o, 2'b00);
    check("t4_scyc", S_CYC_O, 0);
    check("t4_m1ack", M1_ACK_O, 0);
    M1_CYC_I = 0; M1_STB_I = 0;
    S_ACK_I = 1; S_DAT_I = 32'h55AA_55AA;
    settle();
    check("t4_late_m1ack", M1_ACK_O, 0);
    check("t4_late_m0ack", M0_ACK_O, 0);
    check("t4_late_m1dat", M1_DAT_O, 0);
    step();
    check("t5_spurious_m0ack", M0_ACK_O, 0);
    check("t5_spurious_m0dat", M0_DAT_O, 0);
    check("t5_gnt", gnt_o, 2'b00);
    S_ACK_I = 0; S_DAT_I = '0;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled M0 read: synthetic ACK after eight stalled cycles
    M0_CYC_I = 1; M0_STB_I = 1; M0_WE_I = 0; M0_ADR_I = 32'h600;
    step();
    check("t6_gnt", gnt_o, 2'b01);
    sb.push_back('{m: 1'b0, d: 32'hDEAD_BEEF});
    for (int i = 0; i < 8; i++) begin
      check("t6_stall_stb", S_STB_O, 1);
      check("t6_stall_timeout", timeout_o, 0);
      step();
    end
    check("t6_timeout", timeout_o, 1);
    check("t6_sstb_forced", S_STB_O, 0);
    check("t6_scyc_forced", S_CYC_O, 0);
    check("t6_m0ack", M0_ACK_O, 1);
    check("t6_m0dat", M0_DAT_O, 32'hDEAD_BEEF);
    step();
    check("t6_timeout_once", timeout_o, 0);
    check("t6_sstb_back", S_STB_O, 1);
    M0_CYC_I = 0; M0_STB_I = 0;
    step();
    check("t6_release", gnt_o, 2'b00);
`endif

    step();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master to one-slave Wishbone B4 classic arbiter; shares the single interconnect master port between requesters.
- Typical requesters: M0 = CPU wb_master, M1 = a DMA or debug master.
- Sits between the masters and wb_interconnect. Round-robin grant, held for the full CYC burst.
- Routes request signals downstream and routes ACK/read data back to the owner only.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; SEL width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, ACK watchdog limit in clock cycles. Used only with WB_ARB_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- M0_CYC_I  in  1  master 0 bus cycle request.
- M0_STB_I  in  1  master 0 strobe.
- M0_WE_I  in  1  master 0 write enable.
- M0_SEL_I  in  DATA_WIDTH/8  master 0 byte select.
- M0_ADR_I  in  ADDR_WIDTH  master 0 address.
- M0_DAT_I  in  DATA_WIDTH  master 0 write data.
- M0_DAT_O  out  DATA_WIDTH  read data to master 0.
- M0_ACK_O  out  1  acknowledge to master 0.
- M1_*: identical set for master 1.
- S_CYC_O, S_STB_O, S_WE_O  out  1  to interconnect.
- S_SEL_O  out  DATA_WIDTH/8  to interconnect.
- S_ADR_O  out  ADDR_WIDTH  to interconnect.
- S_DAT_O  out  DATA_WIDTH  to interconnect.
- S_DAT_I  in  DATA_WIDTH  read data from interconnect.
- S_ACK_I  in  1  acknowledge from interconnect.
- gnt_o  out  2  one-hot current grant; 00 = idle.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - state = IDLE, gnt_o = 00, last-grant pointer = M1 (so M0 wins first), watchdog = 0, timeout_o = 0.
  - All S_* outputs and M*_ACK_O are 0; M*_DAT_O = 0.
  - Reset mid-cycle aborts the transfer with no ACK to any master.
- States:
  - IDLE: no owner. If exactly one M*_CYC_I is high, go to GNT0 or GNT1 accordingly. If both are high, grant the master that is not the last-grant pointer.
  - GNT0 / GNT1: owner fixed. Leave only when the owner's CYC_I is low at a clock edge.
  - On leaving: update the last-grant pointer to the owner. Then, in the same edge, grant the other master if its CYC_I is high (direct handoff, no idle bubble), else go to IDLE.
  - An owner that re-raises CYC immediately loses to a waiting peer (fairness).
- Latency:
  - Grant is registered: the first cycle a master raises CYC from IDLE, S_CYC_O stays 0. S_* follow the owner from the next cycle.
  - In a granted state, muxing is purely combinational (zero added latency).
- Datapath:
  - S_CYC_O/S_STB_O/S_WE_O/S_SEL_O/S_ADR_O/S_DAT_O = owner's signals. When gnt_o = 00 all are 0.
  - Owner's ACK_O = S_ACK_I; the non-owner's ACK_O = 0.
  - M*_DAT_O = S_DAT_I for the owner, 0 for the non-owner.
- Boundary conditions:
  - S_ACK_I with no grant: dropped.
  - Owner drops CYC in the same cycle S_ACK_I is high: that ACK still passes combinationally to the owner; the grant is released at the edge.
  - Non-owner requests are never lost; they are held until granted.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles with S_STB_O=1 and S_ACK_I=0. It clears on ACK or on grant change.
  - When the count reaches TIMEOUT_CYCLES, for exactly one cycle: S_STB_O and S_CYC_O are forced 0, a synthetic ACK goes to the owner with DAT_O = 32'hDEAD_BEEF, and timeout_o pulses.
  - The counter then clears. The grant is released as in normal operation when the owner drops CYC.
- Not defined: no counter logic; timeout_o tied to 0.

Decomposition:
- Package wb_arb_pkg:
  - state enum arb_state_t {IDLE, GNT0, GNT1};
  - localparam NUM_MASTERS = 2;
  - TIMEOUT_DATA = 32'hDEAD_BEEF;
  - TIMEOUT_W = 16.
- One sub-module: wb_arb_watchdog (counter, compare, pulse), instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- M0 only: read ADR 0x40, slave ACKs after 2 cycles with 0x1234_5678. Required: S_CYC_O rises 1 cycle after M0_CYC_I; M0_DAT_O = 0x1234_5678 with M0_ACK_O; M1_ACK_O = 0; gnt_o = 01.
- Both raise CYC in IDLE right after reset: M0 granted first. When M0 drops CYC, direct handoff to M1 on the same edge (gnt_o 01 -> 10, no 00 cycle).
- M1 owns and holds CYC for 5 writes, then drops and immediately re-requests while M0 waits: grant goes to M0. M1's 5 writes (ADR 0x10..0x20, SEL 4'hF) appear unchanged on S_*.
- rst_i asserted mid-read while in GNT1: next cycle gnt_o = 00, S_CYC_O = 0, no ACK to M1. A late S_ACK_I is dropped.
- Spurious S_ACK_I with no grant: both M*_ACK_O remain 0.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8: slave never ACKs M0 read. After 8 stalled cycles, M0_ACK_O = 1 with M0_DAT_O = 0xDEAD_BEEF, timeout_o pulses once, S_STB_O = 0 in that cycle.
